// File: rtl/bitserial_alu_seq.sv
// Bit-serial sequencer driving a one-bit ALU slice LSB first; WIDTH cycles per operation.
// Optional OVF_EN macro adds the overflow output and makes SLT use sign ^ overflow.
module bitserial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
`ifdef OVF_EN
    output logic             overflow,
`endif
    output logic             slice_ai,
    output logic             slice_bi,
    output logic             slice_ci,
    output logic             slice_less,
    output logic [2:0]       slice_aluop,
    input  logic             slice_ri,
    input  logic             slice_cinext
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             accept;
    logic             set_bit;
    logic [WIDTH-1:0] r_shift;
`ifdef OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
`ifdef OVF_EN
        ovf_d       = ovf_q;
`endif
        slice_ai    = 1'b0;
        slice_bi    = 1'b0;
        slice_ci    = 1'b0;
        slice_less  = 1'b0;
        slice_aluop = 3'b000;
        accept      = start && (state_q != RUN);
        r_shift     = {slice_ri, r_q[WIDTH-1:1]};
        // carry_q holds the carry into the MSB while the last bit is in the slice
`ifdef OVF_EN
        set_bit     = slice_ri ^ (carry_q ^ slice_cinext);
`else
        set_bit     = slice_ri;
`endif

        case (state_q)
            IDLE: ;
            RUN: begin
                slice_ai    = a_q[0];
                slice_bi    = b_q[0];
                slice_ci    = carry_q;
                slice_aluop = (op_q[1:0] == 2'b11) ? 3'b110 : op_q;
                a_d         = a_q >> 1;
                b_d         = b_q >> 1;
                r_d         = r_shift;
                carry_d     = slice_cinext;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = (op_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, set_bit} : r_shift;
                    zero_d   = (result_d == '0);
                    cout_d   = slice_cinext;
`ifdef OVF_EN
                    ovf_d    = op_q[1] & (carry_q ^ slice_cinext);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            op_d    = aluop;
            carry_d = aluop[2];
            cnt_d   = '0;
            r_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
`ifdef OVF_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_bitserial_alu_seq.sv
// Bench for bitserial_alu_seq (WIDTH=8) with a behavioural one-bit slice attached;
// results are compared against whole-word arithmetic.
module tb_bitserial_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b, result;
    logic [2:0]   aluop, slice_aluop;
    logic         busy, done, cout, zero;
    logic         slice_ai, slice_bi, slice_ci, slice_less, slice_ri, slice_cinext;
`ifdef OVF_EN
    logic         overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int t0       = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    bitserial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .aluop(aluop),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
`ifdef OVF_EN
        .overflow(overflow),
`endif
        .slice_ai(slice_ai), .slice_bi(slice_bi), .slice_ci(slice_ci),
        .slice_less(slice_less), .slice_aluop(slice_aluop),
        .slice_ri(slice_ri), .slice_cinext(slice_cinext)
    );

    // One-bit ALU slice: aluop2 inverts B; 00 AND, 01 OR, 10 SUM, 11 LESS
    logic slice_bb;
    always_comb begin
        slice_bb     = slice_bi ^ slice_aluop[2];
        slice_cinext = (slice_ai & slice_bb) | (slice_ai & slice_ci) | (slice_bb & slice_ci);
        case (slice_aluop[1:0])
            2'b00:   slice_ri = slice_ai & slice_bb;
            2'b01:   slice_ri = slice_ai | slice_bb;
            2'b10:   slice_ri = slice_ai ^ slice_bb ^ slice_ci;
            default: slice_ri = slice_less;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] mop,
                         output logic [W-1:0] r, output logic co, output logic z, output logic ov);
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         set;
        bb  = mop[2] ? ~mb : mb;
        s   = {1'b0, ma} + {1'b0, bb} + (W+1)'(mop[2]);
        ov  = mop[1] && (ma[W-1] == bb[W-1]) && (s[W-1] != ma[W-1]);
`ifdef OVF_EN
        set = s[W-1] ^ ov;
`else
        set = s[W-1];
`endif
        case (mop[1:0])
            2'b00:   r = ma & bb;
            2'b01:   r = ma | bb;
            2'b10:   r = s[W-1:0];
            default: r = {{(W-1){1'b0}}, set};
        endcase
        co = s[W];
        z  = (r == '0);
    endtask

    // Call at a negedge: presents start for one edge and leaves us at the next negedge
    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic [2:0] lop);
        a = la; b = lb; aluop = lop; start = 1'b1;
        t0 = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic [2:0] eop);
        logic [W-1:0] er;
        logic ec, ez, eo;
        int n;
        model(ea, eb, eop, er, ec, ez, eo);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"}, 32'(edge_cnt - t0), 32'(W));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
`ifdef OVF_EN
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
`endif
        $display("%s: a=%02h b=%02h op=%03b -> result=%02h cout=%0b zero=%0b", tag, ea, eb, eop,
                 result, cout, zero);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic [2:0] rop);
        launch(ra, rb, rop);
        wait_done(tag, ra, rb, rop);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [2:0] ops [5];
        logic [W-1:0] ra, rb, pa, pb;
        logic [2:0]   rop, pop;
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b111;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; aluop = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_slice_aluop", 32'(slice_aluop), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add", 8'h5A, 8'h3C, 3'b010);
        run_op("sub_eq", 8'h10, 8'h10, 3'b110);
        run_op("and", 8'hF0, 8'h3C, 3'b000);
        run_op("or", 8'hF0, 8'h3C, 3'b001);

        // SLT: slice must be run as a subtract, carry seeded with 1
        launch(8'h80, 8'h01, 3'b111);
        check("slt_slice_aluop", 32'(slice_aluop), 32'h6);
        check("slt_slice_ci", 32'(slice_ci), 32'd1);
        check("slt_slice_bi", 32'(slice_bi), 32'd1);
        check("slt_slice_less", 32'(slice_less), 32'd0);
        check("slt_busy", 32'(busy), 32'd1);
        wait_done("slt", 8'h80, 8'h01, 3'b111);
        @(negedge clk);

        // Start while running is ignored
        launch(8'h21, 8'h13, 3'b010);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; aluop = 3'b001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_mid", 8'h21, 8'h13, 3'b010);
        @(negedge clk);
        check("ignore_idle", 32'(busy), 32'd0);

        // Reset in the middle of an ADD
        launch(8'h77, 8'h11, 3'b010);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_slice_ai", 32'(slice_ai), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_stays_idle", 32'(busy), 32'd0);
        run_op("after_rst", 8'h77, 8'h11, 3'b010);

        // Randomised ops, some issued on the done cycle back-to-back
        pa = 8'($urandom); pb = 8'($urandom); pop = ops[$urandom_range(0, 4)];
        launch(pa, pb, pop);
        for (int i = 0; i < 40; i++) begin
            wait_done("rand", pa, pb, pop);
            ra = 8'($urandom); rb = 8'($urandom); rop = ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 0) begin
                launch(ra, rb, rop);
                check("b2b_busy", 32'(busy), 32'd1);
            end else begin
                @(negedge clk);
                check("rand_idle_done", 32'(done), 32'd0);
                check("rand_idle_busy", 32'(busy), 32'd0);
                launch(ra, rb, rop);
            end
            pa = ra; pb = rb; pop = rop;
        end
        wait_done("rand_last", pa, pb, pop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
